// File: rtl/divider_wb_master.sv
// divider_wb_master: drives a memory-mapped divider over Wishbone classic and returns quotient/remainder
module divider_wb_master #(
   parameter int WBW = 32,
   parameter int XLEN = 32,
   parameter logic [WBW-1:0] ADR_DIVIDEND = 32'h1000_0000,
   parameter logic [WBW-1:0] ADR_DIVISOR = 32'h2000_0000,
   parameter logic [WBW-1:0] ADR_QUOTIENT = 32'h3000_0000,
   parameter logic [WBW-1:0] ADR_REMAINDER = 32'h4000_0000,
   parameter logic [WBW-1:0] ADR_CTRL = 32'h0100_0000,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [XLEN-1:0]   cmd_dividend_i,
   input  logic [XLEN-1:0]   cmd_divisor_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [XLEN-1:0]   rsp_quotient_o,
   output logic [XLEN-1:0]   rsp_remainder_o,
   output logic              rsp_err_o,
   output logic              busy_o,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [WBW/8-1:0]  wbm_sel_o,
   output logic [WBW-1:0]    wbm_adr_o,
   output logic [WBW-1:0]    wbm_dat_o,
   input  logic              wbm_ack_i,
   input  logic [WBW-1:0]    wbm_dat_i
);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [3:0] {IDLE, WR_DVD, WR_DVS, WR_GO, POLL, RD_QUO, RD_REM, GAP, RESP} state_t;
   state_t state, state_n, ret, ret_n;
   logic [XLEN-1:0] dvd, dvs;
   logic [CW-1:0] cnt;
   logic bus, ack, tmo, hs, dz;
   assign bus = state inside {WR_DVD, WR_DVS, WR_GO, POLL, RD_QUO, RD_REM};
   // acks only count while a cycle is open, so stray acks on an idle bus are ignored
   assign ack = bus & wbm_ack_i;
   assign tmo = bus & ~wbm_ack_i & (cnt == CW'(ACK_TIMEOUT - 1));
   assign cmd_ready_o = (state == IDLE) & ~reset_i;
   assign hs = cmd_valid_i & cmd_ready_o;
   assign dz = cmd_divisor_i == '0;
   assign busy_o = state != IDLE;
   assign wbm_cyc_o = bus;
   assign wbm_stb_o = bus;
   assign wbm_we_o = state inside {WR_DVD, WR_DVS, WR_GO};
   assign wbm_sel_o = bus ? '1 : '0;
   // bus address and write data follow the state, so they stay stable until ack
   always_comb begin
      wbm_adr_o = '0;
      wbm_dat_o = '0;
      case (state)
         WR_DVD: begin wbm_adr_o = ADR_DIVIDEND; wbm_dat_o = dvd; end
         WR_DVS: begin wbm_adr_o = ADR_DIVISOR; wbm_dat_o = dvs; end
         WR_GO: begin wbm_adr_o = ADR_CTRL; wbm_dat_o = WBW'(1); end
         POLL: wbm_adr_o = ADR_CTRL;
         RD_QUO: wbm_adr_o = ADR_QUOTIENT;
         RD_REM: wbm_adr_o = ADR_REMAINDER;
         default: ;
      endcase
   end
   // state and gap-return registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
         ret <= IDLE;
      end else begin
         state <= state_n;
         ret <= ret_n;
      end
   end
   // next state: every transaction ends in GAP, which then resumes at ret
   always_comb begin
      state_n = state;
      ret_n = ret;
      case (state)
         IDLE: if (hs) begin state_n = dz ? RESP : GAP; ret_n = WR_DVD; end
         WR_DVD: if (ack) begin state_n = GAP; ret_n = WR_DVS; end
         WR_DVS: if (ack) begin state_n = GAP; ret_n = WR_GO; end
         WR_GO: if (ack) begin state_n = GAP; ret_n = POLL; end
         POLL: if (ack) begin state_n = GAP; ret_n = wbm_dat_i[1] ? RD_QUO : POLL; end
         RD_QUO: if (ack) begin state_n = GAP; ret_n = RD_REM; end
         RD_REM: if (ack) begin state_n = GAP; ret_n = RESP; end
         GAP: state_n = ret;
         RESP: if (rsp_valid_o & rsp_ready_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (tmo) state_n = RESP;
   end
   // operand latch, ack wait counter and response registers; rsp_valid_o rises one cycle into RESP
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         dvd <= '0;
         dvs <= '0;
         cnt <= '0;
         rsp_valid_o <= 1'b0;
         rsp_quotient_o <= '0;
         rsp_remainder_o <= '0;
         rsp_err_o <= 1'b0;
      end else begin
         cnt <= bus ? cnt + CW'(1) : '0;
         rsp_valid_o <= (state == RESP) & ~(rsp_valid_o & rsp_ready_i);
         if (hs) begin
            dvd <= cmd_dividend_i;
            dvs <= cmd_divisor_i;
            rsp_quotient_o <= dz ? '1 : '0;
            rsp_remainder_o <= dz ? cmd_dividend_i : '0;
            rsp_err_o <= dz;
         end
         if (ack && state == RD_QUO) rsp_quotient_o <= wbm_dat_i;
         if (ack && state == RD_REM) rsp_remainder_o <= wbm_dat_i;
         if (tmo) begin
            rsp_quotient_o <= '0;
            rsp_remainder_o <= '0;
            rsp_err_o <= 1'b1;
         end
      end
   end
endmodule
